// File: rtl/apb_master_arb_if.sv
// apb_master_arb_if
//   Bundles the requester channels, the response channel, the timeout setting
//   and the APB bus of apb_master_arb.
//   master modport: the arbiter's view. It drives req_gnt, rsp_* and apb_*
//                   outputs, and samples the requests, tmo_cycles, apb_prdata
//                   and apb_pready.
//   slave modport : the opposite view, used by the requesters, the slave and
//                   the environment.
interface apb_master_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 2,
  parameter int TMO_WIDTH  = 16
);
  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_rnw;
  logic [NREQ*ADDR_WIDTH-1:0] req_addr;
  logic [NREQ*DATA_WIDTH-1:0] req_wdata;
  logic [NREQ-1:0]            req_gnt;
  logic [NREQ-1:0]            rsp_done;
  logic [DATA_WIDTH-1:0]      rsp_rdata;
  logic                       rsp_err;
  logic [TMO_WIDTH-1:0]       tmo_cycles;
  logic [ADDR_WIDTH-1:0]      apb_paddr;
  logic                       apb_psel;
  logic                       apb_penable;
  logic                       apb_pwrite;
  logic [DATA_WIDTH-1:0]      apb_pwdata;
  logic [DATA_WIDTH-1:0]      apb_prdata;
  logic                       apb_pready;

  modport master (
    input  req_valid, req_rnw, req_addr, req_wdata, tmo_cycles,
           apb_prdata, apb_pready,
    output req_gnt, rsp_done, rsp_rdata, rsp_err,
           apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
  );

  modport slave (
    output req_valid, req_rnw, req_addr, req_wdata, tmo_cycles,
           apb_prdata, apb_pready,
    input  req_gnt, rsp_done, rsp_rdata, rsp_err,
           apb_paddr, apb_psel, apb_penable, apb_pwrite, apb_pwdata
  );
endinterface

// File: rtl/apb_master_arb.sv
// apb_master_arb
//   Round-robin arbiter plus APB master sequencer. NREQ requesters share one
//   APB bus. A request transfers when req_valid[i] && req_gnt[i]. The block
//   runs SETUP and ACCESS, waits for pready, and returns the result to the
//   winner as a one-cycle rsp_done pulse with rsp_rdata and rsp_err. A
//   non-zero tmo_cycles bounds the number of ACCESS cycles.
//   Ports: clk, nrst (async, active-low), bus (apb_master_arb_if.master).
//
//   state  | meaning
//   IDLE   | arbitrate; combinational grant; latch winner into APB regs
//   SETUP  | psel=1, penable=0; clear timeout counter
//   ACCESS | psel=1, penable=1; wait for pready or timeout
module apb_master_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NREQ       = 2,
  parameter int TMO_WIDTH  = 16
) (
  input logic               clk,
  input logic               nrst,
  apb_master_arb_if.master  bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t                 state_q;
  logic [IDX_W-1:0]       last_q;
  logic [IDX_W-1:0]       id_q;
  logic [TMO_WIDTH-1:0]   cnt_q;
  logic [ADDR_WIDTH-1:0]  paddr_q;
  logic [DATA_WIDTH-1:0]  pwdata_q;
  logic                   pwrite_q;
  logic                   psel_q;
  logic                   penable_q;
  logic [NREQ-1:0]        rsp_done_q;
  logic [DATA_WIDTH-1:0]  rsp_rdata_q;
  logic                   rsp_err_q;

  logic [ADDR_WIDTH-1:0]  addr_a  [NREQ];
  logic [DATA_WIDTH-1:0]  wdata_a [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_a[g]  = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_a[g] = bus.req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
  end

  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic [NREQ-1:0]  gnt;

  // Search starts just after the last winner, so a requester that keeps
  // valid high cannot win twice while another is waiting.
  always_comb begin
    found   = 1'b0;
    win_idx = last_q;
    cand    = last_q;
    gnt     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_q) + k) % NREQ);
      if (!found && bus.req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    if (state_q == IDLE && found) gnt[win_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NREQ - 1);
      id_q        <= '0;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pwrite_q    <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_done_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (found) begin
            paddr_q  <= addr_a[win_idx];
            pwdata_q <= wdata_a[win_idx];
            pwrite_q <= ~bus.req_rnw[win_idx];
            last_q   <= win_idx;
            id_q     <= win_idx;
            psel_q   <= 1'b1;
            state_q  <= SETUP;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          cnt_q     <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (bus.apb_pready) begin
            rsp_rdata_q      <= pwrite_q ? '0 : bus.apb_prdata;
            rsp_err_q        <= 1'b0;
            rsp_done_q[id_q] <= 1'b1;
            psel_q           <= 1'b0;
            penable_q        <= 1'b0;
            state_q          <= IDLE;
          end else if (bus.tmo_cycles != '0 &&
                       cnt_q == bus.tmo_cycles - TMO_WIDTH'(1)) begin
            rsp_rdata_q      <= '0;
            rsp_err_q        <= 1'b1;
            rsp_done_q[id_q] <= 1'b1;
            psel_q           <= 1'b0;
            penable_q        <= 1'b0;
            state_q          <= IDLE;
          end else begin
            cnt_q <= cnt_q + TMO_WIDTH'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_gnt     = gnt;
  assign bus.rsp_done    = rsp_done_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.apb_paddr   = paddr_q;
  assign bus.apb_psel    = psel_q;
  assign bus.apb_penable = penable_q;
  assign bus.apb_pwrite  = pwrite_q;
  assign bus.apb_pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// tb_apb_master_arb
//   Directed bench for apb_master_arb with NREQ=2. Inputs change 1 ns after
//   the rising edge, and outputs are checked 1-2 ns after it.
module tb_apb_master_arb;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int TW = 16;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;

  apb_master_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR), .TMO_WIDTH(TW)) bus ();

  apb_master_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NREQ(NR), .TMO_WIDTH(TW)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic rnw, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    bus.req_rnw[i]                 = rnw;
    bus.req_addr[i*AW +: AW]       = a;
    bus.req_wdata[i*DW +: DW]      = d;
  endtask

  initial begin
    int aborts;
    logic [NR-1:0] exp_g;
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    bus.req_valid  = '0;
    bus.req_rnw    = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.tmo_cycles = '0;
    bus.apb_prdata = '0;
    bus.apb_pready = 1'b0;

    // reset state
    repeat (3) cyc();
    chk("rst_psel",    bus.apb_psel, 0);
    chk("rst_penable", bus.apb_penable, 0);
    chk("rst_pwrite",  bus.apb_pwrite, 0);
    chk("rst_paddr",   bus.apb_paddr, 0);
    chk("rst_pwdata",  bus.apb_pwdata, 0);
    chk("rst_done",    bus.rsp_done, 0);
    chk("rst_rdata",   bus.rsp_rdata, 0);
    chk("rst_err",     bus.rsp_err, 0);
    chk("rst_gnt",     bus.req_gnt, 0);
    nrst = 1'b1;
    cyc();

    // single write, pready immediately
    set_req(0, 1'b0, 32'h100, 32'hDEADBEEF);
    bus.apb_pready = 1'b1;
    bus.req_valid  = 2'b01;
    #1;
    chk("wr_gnt_T", bus.req_gnt, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    #1;
    chk("wr_psel_T1",    bus.apb_psel, 1);
    chk("wr_penable_T1", bus.apb_penable, 0);
    chk("wr_pwrite",     bus.apb_pwrite, 1);
    chk("wr_paddr",      bus.apb_paddr, 32'h100);
    chk("wr_pwdata",     bus.apb_pwdata, 32'hDEADBEEF);
    chk("wr_gnt_setup",  bus.req_gnt, 0);
    cyc();
    chk("wr_penable_T2", bus.apb_penable, 1);
    cyc();
    chk("wr_done_T3",    bus.rsp_done, 2'b01);
    chk("wr_err",        bus.rsp_err, 0);
    chk("wr_rdata",      bus.rsp_rdata, 0);
    chk("wr_psel_T3",    bus.apb_psel, 0);
    chk("wr_penable_T3", bus.apb_penable, 0);
    cyc();
    chk("wr_done_pulse", bus.rsp_done, 0);

    // read on requester 1 with 4 ACCESS cycles
    set_req(1, 1'b1, 32'h20, 32'h0);
    bus.apb_pready = 1'b0;
    bus.req_valid  = 2'b10;
    #1;
    chk("rd_gnt", bus.req_gnt, 2'b10);
    cyc();
    bus.req_valid = 2'b00;
    chk("rd_pwrite", bus.apb_pwrite, 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("rd_wait_paddr",   bus.apb_paddr, 32'h20);
      chk("rd_wait_penable", bus.apb_penable, 1);
      chk("rd_wait_done",    bus.rsp_done, 0);
      cyc();
    end
    bus.apb_pready = 1'b1;
    bus.apb_prdata = 32'h12345678;
    chk("rd_last_paddr", bus.apb_paddr, 32'h20);
    cyc();
    chk("rd_done",  bus.rsp_done, 2'b10);
    chk("rd_rdata", bus.rsp_rdata, 32'h12345678);
    chk("rd_err",   bus.rsp_err, 0);

    // round robin, both valid continuously
    set_req(0, 1'b1, 32'h40, 32'h0);
    set_req(1, 1'b1, 32'h80, 32'h0);
    bus.apb_prdata = 32'hA5A50000;
    cyc();
    bus.req_valid = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
      exp_g = (n % 2 == 0) ? 2'b01 : 2'b10;
      chk("rr_gnt", bus.req_gnt, exp_g);
      cyc();
      chk("rr_paddr", bus.apb_paddr, (n % 2 == 0) ? 32'h40 : 32'h80);
      cyc();
      cyc();
      chk("rr_done", bus.rsp_done, exp_g);
      if (n == 3) bus.req_valid = 2'b00;
      #1;
    end
    chk("rr_rdata", bus.rsp_rdata, 32'hA5A50000);

    // timeout after 5 ACCESS cycles
    cyc();
    bus.tmo_cycles = 16'd5;
    bus.apb_pready = 1'b0;
    set_req(0, 1'b0, 32'h300, 32'h11);
    bus.req_valid = 2'b01;
    #1;
    chk("tmo_gnt", bus.req_gnt, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("tmo_access_penable", bus.apb_penable, 1);
      chk("tmo_access_done",    bus.rsp_done, 0);
      cyc();
    end
    chk("tmo_psel",  bus.apb_psel, 0);
    chk("tmo_done",  bus.rsp_done, 2'b01);
    chk("tmo_err",   bus.rsp_err, 1);
    chk("tmo_rdata", bus.rsp_rdata, 0);
    cyc();
    set_req(1, 1'b0, 32'h304, 32'h22);
    bus.apb_pready = 1'b1;
    bus.req_valid  = 2'b10;
    #1;
    chk("post_tmo_gnt", bus.req_gnt, 2'b10);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    cyc();
    chk("post_tmo_done", bus.rsp_done, 2'b10);
    chk("post_tmo_err",  bus.rsp_err, 0);

    // timeout disabled, 100 wait cycles
    cyc();
    bus.tmo_cycles = 16'd0;
    bus.apb_pready = 1'b0;
    set_req(0, 1'b1, 32'h44, 32'h0);
    bus.req_valid = 2'b01;
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    aborts = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.rsp_done != 0 || bus.apb_penable != 1'b1) aborts++;
      cyc();
    end
    chk("notmo_no_abort", aborts, 0);
    bus.apb_pready = 1'b1;
    bus.apb_prdata = 32'hCAFEF00D;
    cyc();
    chk("notmo_done",  bus.rsp_done, 2'b01);
    chk("notmo_rdata", bus.rsp_rdata, 32'hCAFEF00D);
    chk("notmo_err",   bus.rsp_err, 0);

    // reset during ACCESS
    cyc();
    bus.apb_pready = 1'b0;
    set_req(1, 1'b1, 32'h50, 32'h0);
    bus.req_valid = 2'b10;
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    chk("mr_penable_before", bus.apb_penable, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk("mr_psel_async",    bus.apb_psel, 0);
    chk("mr_penable_async", bus.apb_penable, 0);
    cyc();
    chk("mr_no_done", bus.rsp_done, 0);
    nrst = 1'b1;
    bus.apb_pready = 1'b1;
    bus.req_valid  = 2'b11;
    #1;
    chk("mr_gnt_prio0", bus.req_gnt, 2'b01);
    cyc();
    bus.req_valid = 2'b00;
    cyc();
    cyc();
    chk("mr_done", bus.rsp_done, 2'b01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
